// File: rtl/ttl_bcd_timer_ctrl_pkg.sv
// ttl_bcd_timer_ctrl_pkg
//   Shared definitions for the BCD interval timer controller and its decade stages.
//   Contents:
//     state_e   - controller state encodings (IDLE / RUN / DONE)
//     BCD_NINE  - the terminal digit value that enables ripple into the next stage
//     bcd_step  - next value of one decade stage when it is told to step,
//                 including recovery of the six non-BCD codes
package ttl_bcd_timer_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [3:0] BCD_NINE = 4'b1001;

   // A stage holding an illegal code is pulled back into the 0..9 range on its next
   // step, following the behaviour of a classic TTL decade counter.
   function automatic logic [3:0] bcd_step(input logic [3:0] digit);
      logic [3:0] nextDigit;
      case (digit)
         4'b1001:                   nextDigit = 4'b0000;
         4'b1010, 4'b1100, 4'b1110: nextDigit = BCD_NINE;
         4'b1011:                   nextDigit = 4'b0100;
         4'b1101, 4'b1111:          nextDigit = 4'b0000;
         default:                   nextDigit = digit + 4'd1;
      endcase
      return nextDigit;
   endfunction

endpackage

// File: rtl/ttl_bcd_digit.sv
// ttl_bcd_digit
//   One decade stage of the timer cascade.
//   Ports:
//     Clk         in   clock, rising edge
//     Clear_bar   in   asynchronous active-low reset (stage clears to 0)
//     Load        in   load Load_value on this edge (wins over Step)
//     Load_value  in   4-bit BCD value to load
//     Step        in   advance one count on this edge
//     Q           out  current digit value
//     Is_nine     out  digit currently holds 9 (ripple enable for the next stage)
module ttl_bcd_digit
   import ttl_bcd_timer_ctrl_pkg::*;
(
   input  logic       Clk,
   input  logic       Clear_bar,
   input  logic       Load,
   input  logic [3:0] Load_value,
   input  logic       Step,
   output logic [3:0] Q,
   output logic       Is_nine
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Load takes precedence so a reload on a match edge never also counts.
   always_comb begin
      digit_d = digit_q;
      if (Load) begin
         digit_d = Load_value;
      end else if (Step) begin
         digit_d = bcd_step(digit_q);
      end
   end

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         digit_q <= 4'b0000;
      end else begin
         digit_q <= digit_d;
      end
   end

   // Illegal codes are deliberately "not nine", so they block the ripple.
   assign Q       = digit_q;
   assign Is_nine = (digit_q == BCD_NINE);

endmodule

// File: rtl/ttl_bcd_timer_ctrl.sv
// ttl_bcd_timer_ctrl
//   Start/stop/reload sequencer for a cascade of DIGITS decade counter stages.
//   The count is loaded from Preset, increments in BCD while enabled, and on reaching
//   Match either stops (one-shot) or reloads Preset (auto-reload).
//   Ports:
//     Clk        in   clock, rising edge
//     Clear_bar  in   asynchronous active-low reset
//     Start      in   load Preset and run (honoured in IDLE and DONE only)
//     Stop       in   abort to IDLE, highest priority
//     Enable     in   count enable while running (low = hold)
//     Reload     in   1 = reload Preset on match, 0 = stop on match
//     Preset     in   BCD start value, digit 0 in bits [3:0]
//     Match      in   BCD terminal value
//     Q          out  current count
//     Running    out  controller is in RUN
//     Done       out  one-cycle pulse after each matching edge
//     RCO        out  Running && Enable && every digit is 9 (combinational)
module ttl_bcd_timer_ctrl
   import ttl_bcd_timer_ctrl_pkg::*;
#(
   parameter int DIGITS     = 3,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                Clk,
   input  logic                Clear_bar,
   input  logic                Start,
   input  logic                Stop,
   input  logic                Enable,
   input  logic                Reload,
   input  logic [4*DIGITS-1:0] Preset,
   input  logic [4*DIGITS-1:0] Match,
   output logic [4*DIGITS-1:0] Q,
   output logic                Running,
   output logic                Done,
   output logic                RCO
);

   localparam int W = 4 * DIGITS;

   state_e          state_q;
   logic            running_q;
   logic            done_q;

   logic [W-1:0]    count_w;
   logic [DIGITS-1:0] nine_w;
   logic [DIGITS-1:0] step_w;

   logic            countEn;
   logic            isMatch;
   logic            loadEn;
   logic            stepIn;

   // Rise/fall transport delays only exist in the behavioural TTL model; the
   // synthesizable outputs are zero-delay whatever these parameters say.
   if ((DELAY_RISE != 0) || (DELAY_FALL != 0)) begin : g_delay_ignored
   end

   // The comparison uses the pre-increment count, so the matching value is held for a
   // full cycle before the controller reacts to it.
   always_comb begin
      countEn = (state_q == ST_RUN) && !Stop && Enable;
      isMatch = (count_w == Match);
      loadEn  = (!Stop && Start && ((state_q == ST_IDLE) || (state_q == ST_DONE)))
             || (countEn && isMatch && Reload);
      stepIn  = countEn && !isMatch;
   end

   // Each stage steps only when every lower stage sits at 9; the AND-reduce over the
   // lower nine flags avoids a self-referencing ripple vector.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_first
         assign step_w[g] = stepIn;
      end else begin : g_upper
         assign step_w[g] = stepIn && (&nine_w[g-1:0]);
      end

      ttl_bcd_digit u_digit (
         .Clk        (Clk),
         .Clear_bar  (Clear_bar),
         .Load       (loadEn),
         .Load_value (Preset[4*g +: 4]),
         .Step       (step_w[g]),
         .Q          (count_w[4*g +: 4]),
         .Is_nine    (nine_w[g])
      );
   end

   // Controller FSM. Running and Done are registered alongside the state; Done is a
   // single-cycle pulse because it is cleared on every edge that does not match.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!Stop && Start) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (Stop) begin
                  state_q   <= ST_IDLE;
                  running_q <= 1'b0;
               end else if (Enable && isMatch) begin
                  done_q <= 1'b1;
                  if (!Reload) begin
                     state_q   <= ST_DONE;
                     running_q <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (Stop) begin
                  state_q   <= ST_IDLE;
                  running_q <= 1'b0;
               end else if (Start) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign Q       = count_w;
   assign Running = running_q;
   assign Done    = done_q;
   assign RCO     = running_q && Enable && (&nine_w);

endmodule

// File: tb/tb_ttl_bcd_timer_ctrl.sv
// tb_ttl_bcd_timer_ctrl
//   Directed self-checking bench for the BCD interval timer controller (3 digits).
module tb_ttl_bcd_timer_ctrl;

   logic        Clk;
   logic        Clear_bar;
   logic        Start;
   logic        Stop;
   logic        Enable;
   logic        Reload;
   logic [11:0] Preset;
   logic [11:0] Match;
   logic [11:0] Q;
   logic        Running;
   logic        Done;
   logic        RCO;

   int passCount;
   int checkCount;

   ttl_bcd_timer_ctrl #(
      .DIGITS     (3),
      .DELAY_RISE (0),
      .DELAY_FALL (0)
   ) dut (
      .Clk       (Clk),
      .Clear_bar (Clear_bar),
      .Start     (Start),
      .Stop      (Stop),
      .Enable    (Enable),
      .Reload    (Reload),
      .Preset    (Preset),
      .Match     (Match),
      .Q         (Q),
      .Running   (Running),
      .Done      (Done),
      .RCO       (RCO)
   );

   // Free-running 10-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Drive the control inputs together.
   task automatic applyStimulus(input logic start, input logic stop,
                                input logic enable, input logic reload);
      Start  = start;
      Stop   = stop;
      Enable = enable;
      Reload = reload;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Compare Q, Running and Done against hand-computed values.
   task automatic checkOutput(input string tag, input logic [11:0] expQ,
                              input logic expRun, input logic expDone);
      checkCount++;
      assert (Q === expQ) passCount++;
      else $error("[TB] FAIL %s Q observed=%h expected=%h", tag, Q, expQ);
      checkCount++;
      assert (Running === expRun) passCount++;
      else $error("[TB] FAIL %s Running observed=%b expected=%b", tag, Running, expRun);
      checkCount++;
      assert (Done === expDone) passCount++;
      else $error("[TB] FAIL %s Done observed=%b expected=%b", tag, Done, expDone);
   endtask

   task automatic checkRco(input string tag, input logic expRco);
      checkCount++;
      assert (RCO === expRco) passCount++;
      else $error("[TB] FAIL %s RCO observed=%b expected=%b", tag, RCO, expRco);
   endtask

   initial begin
      logic [11:0] oneShotSeq [8];
      logic [11:0] wrapSeq [5];
      oneShotSeq = '{12'h096, 12'h097, 12'h098, 12'h099,
                     12'h100, 12'h101, 12'h102, 12'h103};
      wrapSeq    = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
      passCount  = 0;
      checkCount = 0;

      // Power-on reset.
      Clear_bar = 1'b0;
      Preset    = 12'h000;
      Match     = 12'h000;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      checkOutput("reset", 12'h000, 1'b0, 1'b0);
      checkRco("reset_rco", 1'b0);
      @(negedge Clk);
      Clear_bar = 1'b1;

      // One-shot 095 -> 103.
      $display("[TB] one-shot");
      Preset = 12'h095;
      Match  = 12'h103;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("oneshot_load", 12'h095, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("oneshot_count%0d", i), oneShotSeq[i], 1'b1, 1'b0);
      end
      checkRco("oneshot_rco_103", 1'b0);
      tick();
      checkOutput("oneshot_match", 12'h103, 1'b0, 1'b1);
      tick();
      checkOutput("oneshot_hold", 12'h103, 1'b0, 1'b0);

      // Auto-reload 007..009, started from DONE.
      $display("[TB] reload");
      Preset = 12'h007;
      Match  = 12'h009;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("reload_load", 12'h007, 1'b1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         tick();
         checkOutput($sformatf("reload%0d_008", r), 12'h008, 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("reload%0d_009", r), 12'h009, 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("reload%0d_wrap", r), 12'h007, 1'b1, 1'b1);
      end

      // Stop to IDLE, then hold with Enable low, then Stop+Start together.
      $display("[TB] stop/enable");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("stop_from_run", 12'h007, 1'b0, 1'b0);
      Preset = 12'h050;
      Match  = 12'h999;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("load_050", 12'h050, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      for (int h = 0; h < 5; h++) begin
         tick();
         checkOutput($sformatf("enable_low%0d", h), 12'h050, 1'b1, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("stop_start_same_edge", 12'h050, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("idle_hold", 12'h050, 1'b0, 1'b0);

      // Full-scale wrap 998 -> 999 -> 000 .. 005.
      $display("[TB] wrap");
      Preset = 12'h998;
      Match  = 12'h005;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("wrap_load", 12'h998, 1'b1, 1'b0);
      checkRco("wrap_rco_998", 1'b0);
      tick();
      checkOutput("wrap_999", 12'h999, 1'b1, 1'b0);
      checkRco("wrap_rco_999", 1'b1);
      Enable = 1'b0;
      #1;
      checkRco("wrap_rco_disabled", 1'b0);
      Enable = 1'b1;
      tick();
      checkOutput("wrap_000", 12'h000, 1'b1, 1'b0);
      checkRco("wrap_rco_000", 1'b0);
      for (int w = 0; w < 5; w++) begin
         tick();
         checkOutput($sformatf("wrap_count%0d", w), wrapSeq[w], 1'b1, 1'b0);
      end
      tick();
      checkOutput("wrap_match", 12'h005, 1'b0, 1'b1);

      // Non-BCD recovery: digit 0 = 1011 steps to 0100.
      $display("[TB] non-BCD");
      Preset = 12'h00B;
      Match  = 12'h005;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("nonbcd_load", 12'h00B, 1'b1, 1'b0);
      tick();
      checkOutput("nonbcd_recover", 12'h004, 1'b1, 1'b0);
      tick();
      checkOutput("nonbcd_005", 12'h005, 1'b1, 1'b0);
      tick();
      checkOutput("nonbcd_match", 12'h005, 1'b0, 1'b1);

      // Asynchronous reset mid-RUN at 047.
      $display("[TB] async reset");
      Preset = 12'h040;
      Match  = 12'h999;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         tick();
      end
      checkOutput("pre_reset_047", 12'h047, 1'b1, 1'b0);
      #2;
      Clear_bar = 1'b0;
      #1;
      checkOutput("async_reset", 12'h000, 1'b0, 1'b0);
      @(negedge Clk);
      Clear_bar = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("post_reset_idle", 12'h000, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
